instr_register_calc: RTL and testbench
======================================

# instr_register_calc

Parametrised successor to the instruction register: a DEPTH-entry register file that stores opcode and two signed operands, and computes and stores the result at write time. It adds a registered read port with a valid strobe, an optional auto-increment write pointer with wrap, an occupancy counter and a sticky overflow flag. It sits between the stimulus side (test program over the clocking block) and the checker, and replaces the fixed-size register.

## Interface
- OP_W, 32: operand width, signed two's complement.
- DEPTH, 32: number of entries; power of two, 2..256.
- AW, $clog2(DEPTH): pointer width (derived, not overridden).
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write strobe.
- auto_inc  in  1  1: write at internal pointer, which then increments; 0: write at write_pointer.
- opcode  in  4  instr_register_pkg opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7; 8..15 reserved.
- operand_a, operand_b  in  OP_W each  signed operands.
- write_pointer  in  AW  explicit write address.
- read_pointer  in  AW  read address.
- rd_en  in  1  read request.
- instruction_word  out  4+2*OP_W+2*OP_W+1  {opcode, operand_a, operand_b, result[2*OP_W-1:0], div_err}.
- rd_valid  out  1  instruction_word updated this cycle.
- wptr  out  AW  internal auto-increment pointer.
- count  out  AW+1  number of distinct written entries since reset, saturating at DEPTH.
- overflow  out  1  sticky: an auto_inc write landed on an already-written entry.

## Operation
- Write: load_en=1 at rising edge stores opcode, operands, result, div_err at address A = auto_inc ? wptr : write_pointer.
- Result (2*OP_W, signed, sign-extended): ZERO→0; PASSA→a; PASSB→b; ADD→a+b; SUB→a−b; MULT→a*b (full width); DIV→a/b (truncate toward zero); MOD→a%b (sign of a). DIV/MOD with b=0: result 0, div_err=1. Reserved opcodes: result 0, div_err=1. Otherwise div_err=0.
- Per-entry written bit; count increments when a write hits an entry whose bit is 0, then the bit is set.
- auto_inc write: wptr ← wptr+1 mod DEPTH; if the target entry's written bit was already 1, overflow ← 1 (the write still happens). Explicit writes never set overflow and never move wptr.
- Read: rd_en=1 at edge N → instruction_word = entry[read_pointer] and rd_valid=1 after edge N; rd_en=0 → rd_valid=0, instruction_word holds.
- Same-address read and write on one edge: read returns the old contents (read-first).
- overflow clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert at clk): all entries cleared to opcode ZERO, operands 0, result 0, div_err 0; written bits 0; wptr=0, count=0, overflow=0, rd_valid=0, instruction_word=0.
- Reset asserted mid-operation: state clears immediately, without waiting for clk; an in-flight read is discarded (rd_valid drops to 0).
- Write latency: data readable by rd_en on the edge after the write edge; read latency 1 cycle.
- Result is computed combinationally from the inputs and captured on the write edge; there is no multi-cycle arithmetic.
- Throughput: one write and one read per cycle, independent.

## Test plan
- Reset check: after reset_n low, read every address → instruction_word=0 (opcode ZERO), rd_valid high 1 cycle after each rd_en, count=0, overflow=0.
- Arithmetic: OP_W=32; write ADD 5,−7 / SUB −3,4 / MULT 0x7FFFFFFF,2 / DIV −7,2 / MOD −7,2 / DIV 9,0 → results −2, −7, 0x0_FFFFFFFE, −3, −1, 0 with div_err=1 on the last entry only.
- Auto-increment wrap: DEPTH=8; 9 auto_inc writes → wptr goes 0..7 then 0, count=8, overflow=1 after the 9th write; entry 0 holds the 9th instruction.
- Explicit writes: write addresses 3 twice then 5 → count=2, overflow=0, wptr=0.
- Read-during-write: write address 2 with PASSA 11 while reading 2 (old value PASSA 4) → returns 4; next read returns 11.
- Mid-operation reset: pulse reset_n low between clock edges during back-to-back writes/reads → outputs are 0 immediately, and the next read of any address returns 0.

Source files
------------

// File: rtl/instr_register_calc.sv
// instr_register_calc: DEPTH-entry instruction register file that computes and
// stores the arithmetic result at write time, with a registered read port.
module instr_register_calc #(
  parameter  int OP_W  = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = 4 + 4*OP_W + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_en,
  input  logic                   auto_inc,
  input  logic [3:0]             opcode,
  input  logic signed [OP_W-1:0] operand_a,
  input  logic signed [OP_W-1:0] operand_b,
  input  logic [AW-1:0]          write_pointer,
  input  logic [AW-1:0]          read_pointer,
  input  logic                   rd_en,
  output logic [IW-1:0]          instruction_word,
  output logic                   rd_valid,
  output logic [AW-1:0]          wptr,
  output logic [AW:0]            count,
  output logic                   overflow
);

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  localparam int            RW      = 2*OP_W;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  opcode_t              op;
  logic signed [RW-1:0] a_ext, b_ext, result;
  logic                 div_err, b_zero;
  logic [AW-1:0]        waddr;
  logic [IW-1:0]        wentry;

  logic [IW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic             overflow_q, overflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic [IW-1:0]    iword_q, iword_d;

  assign op     = opcode_t'(opcode);
  assign a_ext  = {{OP_W{operand_a[OP_W-1]}}, operand_a};
  assign b_ext  = {{OP_W{operand_b[OP_W-1]}}, operand_b};
  assign b_zero = (operand_b == '0);

  // Operands are sign-extended to 2*OP_W so MULT keeps the full product.
  always_comb begin
    result  = '0;
    div_err = 1'b0;
    case (op)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV: begin
        if (b_zero) div_err = 1'b1;
        else        result  = a_ext / b_ext;
      end
      MOD: begin
        if (b_zero) div_err = 1'b1;
        else        result  = a_ext % b_ext;
      end
      default: div_err = 1'b1;
    endcase
  end

  assign waddr  = auto_inc ? wptr_q : write_pointer;
  assign wentry = {opcode, operand_a, operand_b, result, div_err};

  always_comb begin
    written_d  = written_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    overflow_d = overflow_q;
    if (load_en) begin
      if (!written_q[waddr]) begin
        written_d[waddr] = 1'b1;
        count_d          = count_q + CNT_ONE;
      end
      if (auto_inc) begin
        wptr_d = wptr_q + PTR_ONE;
        if (written_q[waddr]) overflow_d = 1'b1;
      end
    end
    rd_valid_d = rd_en;
    // mem_q is sampled before this edge's write lands, giving read-first.
    iword_d    = rd_en ? mem_q[read_pointer] : iword_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) mem_q[i] <= '0;
      written_q  <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      iword_q    <= '0;
    end else begin
      if (load_en) mem_q[waddr] <= wentry;
      written_q  <= written_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      iword_q    <= iword_d;
    end
  end

  assign instruction_word = iword_q;
  assign rd_valid         = rd_valid_q;
  assign wptr             = wptr_q;
  assign count            = count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_instr_register_calc.sv
// Directed self-checking bench for instr_register_calc (OP_W=32, DEPTH=8).
module tb_instr_register_calc;

  localparam int OP_W  = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int IW    = 4 + 4*OP_W + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_en, auto_inc, rd_en;
  logic [3:0]    opcode;
  logic [31:0]   operand_a, operand_b;
  logic [AW-1:0] write_pointer, read_pointer;
  logic [IW-1:0] instruction_word;
  logic          rd_valid, overflow;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;

  int tests = 0;
  int fails = 0;

  instr_register_calc #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .auto_inc(auto_inc),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer), .rd_en(rd_en),
    .instruction_word(instruction_word), .rd_valid(rd_valid), .wptr(wptr),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mkw(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] r,
                                        input logic e);
    return {op, a, b, r, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    load_en = 1'b0; auto_inc = 1'b0; rd_en = 1'b0;
    opcode = 4'd0; operand_a = '0; operand_b = '0;
    write_pointer = '0; read_pointer = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic ai, input logic [AW-1:0] addr);
    load_en = 1'b1; auto_inc = ai; opcode = op;
    operand_a = a; operand_b = b; write_pointer = addr;
    tick();
    load_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr);
    rd_en = 1'b1; read_pointer = addr;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    tests++;
    if (wptr !== 3'd0) begin fails++; $display("FAIL reset_wptr got %0d want 0", wptr); end
    tests++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i));
      tests++;
      if (rd_valid !== 1'b1) begin fails++; $display("FAIL reset_read_valid[%0d] got %b want 1", i, rd_valid); end
      tests++;
      if (instruction_word !== '0) begin fails++; $display("FAIL reset_read_word[%0d] got %h want 0", i, instruction_word); end
    end
    tick();
    tests++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid_drop got %b want 0", rd_valid); end
  endtask

  task automatic test_arith();
    logic [3:0]    t_op [8];
    logic [31:0]   t_a  [8];
    logic [31:0]   t_b  [8];
    logic [63:0]   t_r  [8];
    logic          t_e  [8];
    logic [IW-1:0] exp_w;
    t_op[0] = 4'd3; t_a[0] = 32'd5;          t_b[0] = -32'sd7; t_r[0] = -64'sd2;                 t_e[0] = 1'b0;
    t_op[1] = 4'd4; t_a[1] = -32'sd3;        t_b[1] = 32'd4;   t_r[1] = -64'sd7;                 t_e[1] = 1'b0;
    t_op[2] = 4'd5; t_a[2] = 32'h7FFF_FFFF;  t_b[2] = 32'd2;   t_r[2] = 64'h0000_0000_FFFF_FFFE; t_e[2] = 1'b0;
    t_op[3] = 4'd6; t_a[3] = -32'sd7;        t_b[3] = 32'd2;   t_r[3] = -64'sd3;                 t_e[3] = 1'b0;
    t_op[4] = 4'd7; t_a[4] = -32'sd7;        t_b[4] = 32'd2;   t_r[4] = -64'sd1;                 t_e[4] = 1'b0;
    t_op[5] = 4'd6; t_a[5] = 32'd9;          t_b[5] = 32'd0;   t_r[5] = 64'd0;                   t_e[5] = 1'b1;
    t_op[6] = 4'd9; t_a[6] = 32'd1;          t_b[6] = 32'd2;   t_r[6] = 64'd0;                   t_e[6] = 1'b1;
    t_op[7] = 4'd5; t_a[7] = -32'sd3;        t_b[7] = 32'd5;   t_r[7] = -64'sd15;                t_e[7] = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) wr(t_op[i], t_a[i], t_b[i], 1'b0, AW'(i));
    for (int i = 0; i < 8; i++) begin
      rd(AW'(i));
      exp_w = mkw(t_op[i], t_a[i], t_b[i], t_r[i], t_e[i]);
      tests++;
      if (instruction_word !== exp_w) begin
        fails++; $display("FAIL arith_entry[%0d] got %h want %h", i, instruction_word, exp_w);
      end
    end
    tests++;
    if (count !== 4'd8) begin fails++; $display("FAIL arith_count got %0d want 8", count); end
  endtask

  task automatic test_auto_wrap();
    logic [IW-1:0] exp_w;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      wr(4'd1, 32'(100 + k), 32'd0, 1'b1, 3'd3);
      tests++;
      if (wptr !== AW'((k + 1) % DEPTH)) begin
        fails++; $display("FAIL wrap_wptr[%0d] got %0d want %0d", k, wptr, (k + 1) % DEPTH);
      end
      tests++;
      if (overflow !== (k == 8)) begin
        fails++; $display("FAIL wrap_overflow[%0d] got %b want %b", k, overflow, (k == 8));
      end
    end
    tests++;
    if (count !== 4'd8) begin fails++; $display("FAIL wrap_count got %0d want 8", count); end
    rd(3'd0);
    exp_w = mkw(4'd1, 32'd108, 32'd0, 64'd108, 1'b0);
    tests++;
    if (instruction_word !== exp_w) begin fails++; $display("FAIL wrap_entry0 got %h want %h", instruction_word, exp_w); end
    rd(3'd3);
    exp_w = mkw(4'd1, 32'd103, 32'd0, 64'd103, 1'b0);
    tests++;
    if (instruction_word !== exp_w) begin fails++; $display("FAIL wrap_entry3 got %h want %h", instruction_word, exp_w); end
  endtask

  task automatic test_explicit();
    do_reset();
    wr(4'd1, 32'd1, 32'd0, 1'b0, 3'd3);
    tests++;
    if (count !== 4'd1) begin fails++; $display("FAIL expl_count1 got %0d want 1", count); end
    wr(4'd1, 32'd2, 32'd0, 1'b0, 3'd3);
    wr(4'd2, 32'd0, 32'd3, 1'b0, 3'd5);
    tests++;
    if (count !== 4'd2) begin fails++; $display("FAIL expl_count got %0d want 2", count); end
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL expl_overflow got %b want 0", overflow); end
    tests++;
    if (wptr !== 3'd0) begin fails++; $display("FAIL expl_wptr got %0d want 0", wptr); end
  endtask

  task automatic test_read_during_write();
    logic [IW-1:0] old_w, new_w;
    old_w = mkw(4'd1, 32'd4, 32'd0, 64'd4, 1'b0);
    new_w = mkw(4'd1, 32'd11, 32'd0, 64'd11, 1'b0);
    do_reset();
    wr(4'd1, 32'd4, 32'd0, 1'b0, 3'd2);
    load_en = 1'b1; auto_inc = 1'b0; opcode = 4'd1;
    operand_a = 32'd11; operand_b = 32'd0; write_pointer = 3'd2;
    rd_en = 1'b1; read_pointer = 3'd2;
    tick();
    load_en = 1'b0; rd_en = 1'b0;
    tests++;
    if (instruction_word !== old_w) begin fails++; $display("FAIL rdw_old got %h want %h", instruction_word, old_w); end
    tests++;
    if (rd_valid !== 1'b1) begin fails++; $display("FAIL rdw_valid got %b want 1", rd_valid); end
    rd(3'd2);
    tests++;
    if (instruction_word !== new_w) begin fails++; $display("FAIL rdw_new got %h want %h", instruction_word, new_w); end
    tick();
    tests++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL rdw_valid_drop got %b want 0", rd_valid); end
    tests++;
    if (instruction_word !== new_w) begin fails++; $display("FAIL rdw_hold got %h want %h", instruction_word, new_w); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 9; k++) wr(4'd3, 32'(k), 32'd1, 1'b1, 3'd0);
    // Back-to-back write and read in flight when reset pulses between edges.
    load_en = 1'b1; auto_inc = 1'b1; opcode = 4'd1; operand_a = 32'd77; operand_b = 32'd0;
    rd_en = 1'b1; read_pointer = 3'd0;
    tick();
    tests++;
    if (rd_valid !== 1'b1 || instruction_word === '0) begin
      fails++; $display("FAIL midrst_pre got valid=%b word=%h want valid=1 word nonzero", rd_valid, instruction_word);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", rd_valid); end
    tests++;
    if (instruction_word !== '0) begin fails++; $display("FAIL midrst_word got %h want 0", instruction_word); end
    tests++;
    if (count !== 4'd0 || wptr !== 3'd0 || overflow !== 1'b0) begin
      fails++; $display("FAIL midrst_state got count=%0d wptr=%0d ovf=%b want 0/0/0", count, wptr, overflow);
    end
    #1 reset_n = 1'b1;
    load_en = 1'b0; rd_en = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i));
      tests++;
      if (instruction_word !== '0 || rd_valid !== 1'b1) begin
        fails++; $display("FAIL midrst_read[%0d] got word=%h valid=%b want 0/1", i, instruction_word, rd_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_auto_wrap();
    test_explicit();
    test_read_during_write();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
